// File: rtl/serial_alu_pkg.sv
// Shared constants for the bit-serial add/subtract path.
// State encodings, operation codes and the bit-counter width helper.
package serial_alu_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Counter only has to reach WIDTH-1; at least one bit wide.
    function automatic int unsigned cntw(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/adder1b.sv
// Single-bit full-adder cell, time-shared by the serial add/subtract controller.
module adder1b (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract: one adder1b cell, one bit per clock, LSB first.
// Start/busy/done handshake; result and flags hold until the next accepted start.
module serial_addsub_ctrl
    import serial_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned CNTW = cntw(WIDTH);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sh_a_q, sh_a_d;
    logic [WIDTH-1:0] sh_b_q, sh_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic sum;
    logic carry_out;

    adder1b u_adder (
        .s    (sum),
        .cout (carry_out),
        .a    (sh_a_q[0]),
        .b    (sh_b_q[0]),
        .cin  (carry_q)
    );

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        carry_d  = carry_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert b and seed the carry with 1.
                    state_d  = ST_RUN;
                    sh_a_d   = a;
                    sh_b_d   = (op_sub == OP_SUB) ? ~b : b;
                    carry_d  = op_sub;
                    cnt_d    = '0;
                    result_d = '0;
                    cout_d   = 1'b0;
                    ovf_d    = 1'b0;
                    zero_d   = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                carry_d  = carry_out;
                result_d = {sum, result_q[WIDTH-1:1]};
                sh_a_d   = sh_a_q >> 1;
                sh_b_d   = sh_b_q >> 1;
                cnt_d    = cnt_q + CNTW'(1);
                if (cnt_q == CNT_LAST) begin
                    // result_q[WIDTH-1:1] holds every earlier sum bit at this point.
                    cout_d  = carry_out;
                    ovf_d   = carry_q ^ carry_out;
                    zero_d  = ~(|result_q[WIDTH-1:1]) & ~sum;
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            sh_a_q   <= '0;
            sh_b_q   <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_a_q   <= sh_a_d;
            sh_b_q   <= sh_b_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = (state_q == ST_RUN);
    assign done   = (state_q == ST_DONE);
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Directed bench for serial_addsub_ctrl: WIDTH=8 vectors plus an exhaustive WIDTH=4 sweep.
module tb_serial_addsub_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic       start8, op_sub8;
    logic [7:0] a8, b8, result8;
    logic       busy8, done8, cout8, ovf8, zero8;

    logic       start4, op_sub4;
    logic [3:0] a4, b4, result4;
    logic       busy4, done4, cout4, ovf4, zero4;

    int checks = 0;
    int errors = 0;

    serial_addsub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .op_sub (op_sub8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .result (result8),
        .cout   (cout8),
        .ovf    (ovf8),
        .zero   (zero8)
    );

    serial_addsub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start4),
        .op_sub (op_sub4),
        .a      (a4),
        .b      (b4),
        .busy   (busy4),
        .done   (done4),
        .result (result4),
        .cout   (cout4),
        .ovf    (ovf4),
        .zero   (zero4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch8(input logic sub, input logic [7:0] ia, input logic [7:0] ib);
        start8  = 1'b1;
        op_sub8 = sub;
        a8      = ia;
        b8      = ib;
        step();
        start8 = 1'b0;
    endtask

    // Called just after the start edge; returns edges elapsed until done and busy cycles seen.
    task automatic wait_done8(output int edges, output int busy_cycles);
        edges       = 0;
        busy_cycles = 0;
        while (!done8 && edges < 40) begin
            if (busy8) busy_cycles++;
            step();
            edges++;
        end
    endtask

    task automatic op8(input string tag, input logic sub, input logic [7:0] ia,
                       input logic [7:0] ib, input logic [7:0] eres, input logic ecout,
                       input logic eovf, input logic ezero);
        int edges, bc;
        launch8(sub, ia, ib);
        wait_done8(edges, bc);
        check_eq({tag, " latency"}, edges, 8);
        check_eq({tag, " busy_cycles"}, bc, 8);
        check_eq({tag, " result"}, result8, eres);
        check_eq({tag, " cout"}, cout8, ecout);
        check_eq({tag, " ovf"}, ovf8, eovf);
        check_eq({tag, " zero"}, zero8, ezero);
        step();
        check_eq({tag, " done_pulse"}, done8, 0);
        check_eq({tag, " result_hold"}, result8, eres);
    endtask

    int edges, bc, pulses;

    initial begin
        rst_n   = 1'b0;
        start8  = 1'b0;
        op_sub8 = 1'b0;
        a8      = '0;
        b8      = '0;
        start4  = 1'b0;
        op_sub4 = 1'b0;
        a4      = '0;
        b4      = '0;
        step();
        step();
        check_eq("rst busy", busy8, 0);
        check_eq("rst done", done8, 0);
        check_eq("rst result", result8, 0);
        check_eq("rst flags", {cout8, ovf8, zero8}, 0);
        rst_n = 1'b1;
        step();

        op8("add 5a+25", 1'b0, 8'h5A, 8'h25, 8'h7F, 1'b0, 1'b0, 1'b0);
        op8("add ff+01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        op8("add 7f+01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        op8("sub 10-20", 1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0);
        op8("sub 80-01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        op8("sub 33-33", 1'b1, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0, 1'b1);

        // Start held high with different operands during RUN must be ignored.
        launch8(1'b0, 8'h5A, 8'h25);
        start8 = 1'b1;
        op_sub8 = 1'b1;
        a8 = 8'h11;
        b8 = 8'h44;
        pulses = 0;
        for (int i = 0; i < 5; i++) step();
        start8 = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (done8) begin
                pulses++;
                check_eq("held start result", result8, 8'h7F);
            end
            step();
        end
        check_eq("held start pulses", pulses, 1);

        // Start in the DONE cycle: second done lands 9 edges after the first.
        launch8(1'b0, 8'h01, 8'h02);
        wait_done8(edges, bc);
        check_eq("b2b first result", result8, 8'h03);
        start8  = 1'b1;
        op_sub8 = 1'b1;
        a8      = 8'h09;
        b8      = 8'h04;
        step();
        start8 = 1'b0;
        check_eq("b2b busy", busy8, 1);
        wait_done8(edges, bc);
        check_eq("b2b spacing", edges + 1, 9);
        check_eq("b2b second result", result8, 8'h05);
        check_eq("b2b second cout", cout8, 1);
        step();

        // Reset in the middle of RUN aborts without a done pulse.
        launch8(1'b0, 8'hFF, 8'h01);
        for (int i = 0; i < 4; i++) step();
        check_eq("mid busy", busy8, 1);
        rst_n = 1'b0;
        step();
        check_eq("abort busy", busy8, 0);
        check_eq("abort done", done8, 0);
        check_eq("abort result", result8, 0);
        check_eq("abort flags", {cout8, ovf8, zero8}, 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done8) pulses++;
            step();
        end
        check_eq("abort no_done", pulses, 0);
        op8("post rst 01+01", 1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0);

        // Exhaustive WIDTH=4 sweep against an arithmetic model.
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    logic [3:0] ea, eb, bb, eres;
                    logic [4:0] full;
                    logic       eovf;
                    int         n;
                    ea   = 4'(ia);
                    eb   = 4'(ib);
                    bb   = (s == 1) ? ~eb : eb;
                    full = {1'b0, ea} + {1'b0, bb} + 5'(s);
                    eres = full[3:0];
                    eovf = (ea[3] == bb[3]) && (eres[3] != ea[3]);
                    start4  = 1'b1;
                    op_sub4 = (s == 1);
                    a4      = ea;
                    b4      = eb;
                    step();
                    start4 = 1'b0;
                    n = 0;
                    while (!done4 && n < 20) begin
                        step();
                        n++;
                    end
                    check_eq($sformatf("w4 %0d %0h %0h lat", s, ia, ib), n, 4);
                    check_eq($sformatf("w4 %0d %0h %0h res", s, ia, ib), result4, eres);
                    check_eq($sformatf("w4 %0d %0h %0h cout", s, ia, ib), cout4, full[4]);
                    check_eq($sformatf("w4 %0d %0h %0h ovf", s, ia, ib), ovf4, eovf);
                    check_eq($sformatf("w4 %0d %0h %0h zero", s, ia, ib), zero4, eres == 4'h0);
                    step();
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
